onehot_gray_encoder_pipe: RTL
=============================

// Module: onehot_gray_encoder_pipe
// PURPOSE
//  Parametrised, pipelined one-hot to Gray/binary encoder with a valid/ready handshake on both sides.
//  Replaces the fixed 8-bit combinational encoder in datapaths that need backpressure and illegal-input detection.
//  Input vectors that are not one-hot are flagged per beat and counted in a saturating error counter.
// PARAMETERS
//  IN_W       8  one-hot input width; power of two, >= 2
//  ERR_CNT_W  8  error counter width, >= 1
//  OUT_W      -  localparam = $clog2(IN_W); encoded output width
// PORTS
//  clk        in   1          clock, all logic on rising edge
//  rst        in   1          synchronous reset, active-high
//  in_valid   in   1          input beat valid
//  in_ready   out  1          block can accept a beat
//  in_value   in   IN_W       one-hot input vector
//  in_gray    in   1          per-beat mode: 1 = Gray output, 0 = plain binary index
//  out_valid  out  1          output beat valid
//  out_ready  in   1          downstream accepts the beat
//  out_code   out  OUT_W      encoded index of the set bit
//  out_err    out  1          beat input was not one-hot (zero bits or more than one bit set)
//  clr_err    in   1          clear error counter
//  err_count  out  ERR_CNT_W  saturating count of accepted error beats
// BEHAVIOUR
//  Reset: out_valid=0, out_code=0, out_err=0, err_count=0, in_ready=0 while rst is high.
//   Both buffer entries are emptied. in_ready=1 in the first cycle after rst deasserts.
//  Transfers: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
//  Encoding per beat, computed at acceptance:
//   - b = index of the single set bit.
//   - Gray = b ^ (b>>1). Example for IN_W=8, idx 0..7: 000,001,011,010,110,111,101,100.
//   - out_code = in_gray ? Gray : b.
//  Illegal input: popcount(in_value) != 1 gives out_err=1 and out_code=0, in both modes.
//  Storage: 2-entry skid buffer (entries hold code, err). States EMPTY, ONE, FULL.
//   - EMPTY: accept -> ONE.
//   - ONE: accept w/o drain -> FULL; drain w/o accept -> EMPTY; accept+drain -> ONE.
//   - FULL: drain -> ONE. No accept is possible because in_ready=0.
//  in_ready is registered: in_ready = (state != FULL). It does not combinationally depend on out_ready.
//  Latency: 1 cycle. A beat accepted in cycle N is presented with out_valid=1 in cycle N+1 if the buffer was empty.
//  Throughput: 1 beat/cycle sustained while out_ready=1. Strict FIFO order is kept.
//  While out_valid&&!out_ready, out_code and out_err are held stable.
//  out_valid never drops without an output transfer.
//  err_count:
//   - Increments by 1 for each accepted beat with err, on the acceptance cycle.
//   - Saturates at all-ones with no wrap.
//   - clr_err alone sets it to 0.
//   - clr_err and an error acceptance in the same cycle set it to 1.
//  Reset mid-operation: buffered beats are discarded without output. err_count is cleared.
//  in_gray is sampled only with accepted beats. Changing it has no effect on buffered beats.
// TESTING
//  1. IN_W=8, out_ready=1, stream 0x01,0x08,0x80 with in_gray=1 -> out_code 0,2,4 on consecutive cycles, 1-cycle latency.
//  2. Same stream with in_gray=0 -> out_code 0,3,7, out_err=0. Mix modes per beat to confirm per-beat sampling.
//  3. Inputs 0x00 and 0x81 -> out_err=1 and out_code=0 for both; err_count=2. Then clr_err -> err_count=0.
//  4. out_ready=0 for 4 cycles, in_valid=1 continuously:
//     -> exactly 2 beats accepted, in_ready=0 afterwards, outputs held.
//     Release out_ready -> all beats emerge in order with no loss or duplicates.
//  5. ERR_CNT_W=2, 5 illegal beats -> err_count saturates at 3.
//     clr_err together with a 6th illegal beat -> err_count=1.
//  6. IN_W=16: 0x8000 -> binary 15, Gray 8.
//     Assert rst with the buffer FULL -> out_valid=0 next cycle, no stale beat after release, in_ready=1.

Source files
------------

// File: rtl/onehot_gray_encoder_pipe.sv
// ----------------------------------------------------------------------------
// onehot_gray_encoder_pipe
//
// Pipelined one-hot to Gray/binary encoder with valid/ready handshakes on
// both sides. Each accepted beat is encoded at acceptance and stored in a
// 2-entry skid buffer. Beats whose input is not one-hot are flagged with
// out_err and counted in a saturating error counter.
//
// Parameters
//   IN_W       one-hot input width (power of two, >= 2)
//   ERR_CNT_W  error counter width (>= 1)
//   OUT_W      derived, $clog2(IN_W), encoded output width
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   in_valid   input beat valid
//   in_ready   block can accept a beat (registered)
//   in_value   one-hot input vector
//   in_gray    per-beat mode: 1 = Gray output, 0 = plain binary index
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   out_code   encoded index of the set bit (0 for illegal input)
//   out_err    beat input was not one-hot
//   clr_err    clear the error counter
//   err_count  saturating count of accepted error beats
// ----------------------------------------------------------------------------
module onehot_gray_encoder_pipe #(
    parameter  int IN_W      = 8,
    parameter  int ERR_CNT_W = 8,
    localparam int OUT_W     = $clog2(IN_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_value,
    input  logic                 in_gray,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_code,
    output logic                 out_err,
    input  logic                 clr_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 in_ready_q;
    // Entry 0 is the head and drives the outputs; entry 1 is the skid slot.
    logic [OUT_W-1:0]     ent0_code_q, ent0_code_d;
    logic                 ent0_err_q,  ent0_err_d;
    logic [OUT_W-1:0]     ent1_code_q, ent1_code_d;
    logic                 ent1_err_q,  ent1_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;

    logic                 push, pop;
    logic [OUT_W-1:0]     idx;
    logic                 seen, multi;
    logic                 enc_err;
    logic [OUT_W-1:0]     enc_code;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign out_code  = ent0_code_q;
    assign out_err   = ent0_err_q;
    assign err_count = err_cnt_q;

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid && out_ready;

    // Encoder: scan for set bits, remembering whether more than one was seen.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        idx   = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (in_value[i]) begin
                // NOTE: blocking assignments here are intentional; later loop
                // iterations must see the flags updated by earlier ones.
                if (seen) multi = 1'b1;
                seen = 1'b1;
                idx  = OUT_W'(i);
            end
        end
        enc_err = !seen || multi;
        if (enc_err)      enc_code = '0;
        else if (in_gray) enc_code = idx ^ (idx >> 1);
        else              enc_code = idx;
    end

    // Skid-buffer occupancy and entry movement.
    always_comb begin
        state_d     = state_q;
        ent0_code_d = ent0_code_q;
        ent0_err_d  = ent0_err_q;
        ent1_code_d = ent1_code_q;
        ent1_err_d  = ent1_err_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    ent0_code_d = enc_code;
                    ent0_err_d  = enc_err;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    ent0_code_d = enc_code;
                    ent0_err_d  = enc_err;
                end else if (push) begin
                    ent1_code_d = enc_code;
                    ent1_err_d  = enc_err;
                    state_d     = ST_FULL;
                end else if (pop) begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain can happen.
                if (pop) begin
                    ent0_code_d = ent1_code_q;
                    ent0_err_d  = ent1_err_q;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Saturating error counter; a clear coinciding with an error beat
    // leaves the count at one so that beat is not lost.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = (push && enc_err) ? ERR_CNT_W'(1) : '0;
        end else if (push && enc_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the head entry is reset as well because it drives
            // out_code/out_err directly, which must read zero after reset.
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            ent0_code_q <= '0;
            ent0_err_q  <= 1'b0;
            ent1_code_q <= '0;
            ent1_err_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values.
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_FULL);
            ent0_code_q <= ent0_code_d;
            ent0_err_q  <= ent0_err_d;
            ent1_code_q <= ent1_code_d;
            ent1_err_q  <= ent1_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule
